// File: rtl/regfile_dump.sv
// Register file with NRD combinational read ports, one write port and a
// ready/valid dump engine. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_dump #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                dump_start,
    output logic                dump_busy,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data,
    output logic                dump_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(NREGS);
    endfunction

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    logic            wr_en;

    assign wr_en = we && (waddr != '0) && in_range(waddr);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[waddr] = wdata;
        end
        rf_d[0] = '0;
    end

    // NOTE: the storage array is reset on purpose; the dump must report zeros
    // for every entry after reset, so this cannot map onto a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Out-of-range indices read as zero; bypass only for writes that would land.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NRD; k++) begin
            if (in_range(raddr[k*AW +: AW])) begin
                rdata[k*XLEN +: XLEN] = rf_q[raddr[k*AW +: AW]];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (raddr[k*AW +: AW] == waddr)) begin
                rdata[k*XLEN +: XLEN] = wdata;
            end
`else
`endif
        end
    end

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Beat data is always loaded from rf_q, i.e. the value before any write on the same edge.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                    data_d  = rf_q[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SEND: begin
                if (valid_q && dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = rf_q[idx_q + 1'b1];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dump_busy  = busy_q;
    assign dump_valid = valid_q;
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
    assign dump_done  = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed scenarios with literal
// expectations plus a randomized phase compared every cycle against a behavioural model.
module tb_regfile_dump;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                reset;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                dump_start;
    logic                dump_busy;
    logic                dump_valid;
    logic                dump_ready;
    logic [AW-1:0]       dump_idx;
    logic [XLEN-1:0]     dump_data;
    logic                dump_done;

    int checks = 0;
    int errors = 0;

    regfile_dump #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus a dump cursor.
    logic [XLEN-1:0] mrf [NREGS];
    bit              m_valid = 0;
    bit              m_busy  = 0;
    bit              m_done  = 0;
    int              m_idx   = 0;
    logic [XLEN-1:0] m_data  = '0;

    initial begin
        for (int i = 0; i < NREGS; i++) mrf[i] = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < NREGS; i++) mrf[i] = '0;
                m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_data = '0;
            end else begin
                if (m_done) begin
                    m_done = 0;
                    m_busy = 0;
                end else if (!m_busy) begin
                    if (dump_start) begin
                        m_busy = 1; m_valid = 1; m_idx = 0; m_data = mrf[0];
                    end
                end else if (m_valid && dump_ready) begin
                    if (m_idx == NREGS - 1) begin
                        m_valid = 0;
                        m_done  = 1;
                    end else begin
                        m_idx  = m_idx + 1;
                        m_data = mrf[m_idx];
                    end
                end
                if (we && waddr != 0 && int'(waddr) < NREGS) mrf[waddr] = wdata;
            end
        end
    end

    function automatic logic [XLEN-1:0] m_read(input int a);
        if (reset || a >= NREGS) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != 0 && int'(waddr) == a) return wdata;
`endif
        return mrf[a];
    endfunction

    // Compare process: all outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("model_rdata%0d", k), rdata[k*XLEN +: XLEN],
                      m_read(int'(raddr[k*AW +: AW])));
            end
            check("model_valid", dump_valid, reset ? 1'b0 : m_valid);
            check("model_busy",  dump_busy,  reset ? 1'b0 : m_busy);
            check("model_done",  dump_done,  reset ? 1'b0 : m_done);
            if (!reset && m_valid) begin
                check("model_idx",  dump_idx,  m_idx);
                check("model_data", dump_data, m_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [XLEN-1:0] d);
        we = 1'b1; waddr = AW'(a); wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_beat(input int idx);
        bit ok = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (dump_valid && int'(dump_idx) == idx) ok = 1;
        end
        check($sformatf("beat%0d_reached", idx), ok, 1'b1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (dump_done) ok = 1;
        end
        check("done_seen", ok, 1'b1);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        @(negedge clk);
        check("rst_valid", dump_valid, 1'b0);
        check("rst_busy",  dump_busy,  1'b0);
        check("rst_done",  dump_done,  1'b0);
        check("rst_rdata", rdata, '0);

        // Reset clears a written entry.
        tick();
        wr(5, 32'hDEAD_BEEF);
        raddr[0 +: AW] = AW'(5);
        @(negedge clk);
        check("rf5_written", rdata[0 +: XLEN], 32'hDEAD_BEEF);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rf5_in_reset", rdata[0 +: XLEN], 32'h0);
        check("valid_in_reset", dump_valid, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rf5_after_reset", rdata[0 +: XLEN], 32'h0);

        // Writes to x0 are dropped.
        tick();
        raddr[0 +: AW] = '0;
        wr(0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("x0_zero", rdata[0 +: XLEN], 32'h0);

        // Same-cycle write/read of one index.
        tick();
        wr(3, 32'h33);
        raddr[0 +: AW] = AW'(3);
        we = 1'b1; waddr = AW'(3); wdata = 32'hA5A5_A5A5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("bypass_same_cycle", rdata[0 +: XLEN], 32'hA5A5_A5A5);
`else
        check("bypass_same_cycle", rdata[0 +: XLEN], 32'h33);
`endif
        tick();
        we = 1'b0;
        @(negedge clk);
        check("bypass_after_edge", rdata[0 +: XLEN], 32'hA5A5_A5A5);

        // Full dump with constant ready.
        tick();
        for (int i = 1; i < NREGS; i++) wr(i, XLEN'(i * 'h11));
        dump_ready = 1'b1;
        start_dump();
        for (int i = 0; i < NREGS; i++) begin
            @(negedge clk);
            check($sformatf("full_valid%0d", i), dump_valid, 1'b1);
            check($sformatf("full_idx%0d", i),   dump_idx,   i);
            check($sformatf("full_data%0d", i),  dump_data,  XLEN'(i * 'h11));
        end
        @(negedge clk);
        check("full_done_pulse", dump_done, 1'b1);
        check("full_valid_off",  dump_valid, 1'b0);
        check("full_busy_done",  dump_busy, 1'b1);
        @(negedge clk);
        check("full_done_once",  dump_done, 1'b0);
        check("full_busy_off",   dump_busy, 1'b0);

        // Backpressure at index 7 with a write to RF[7] during the stall.
        tick();
        start_dump();
        wait_beat(7);
        dump_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                we = 1'b1; waddr = AW'(7); wdata = 32'h1234;
            end else begin
                we = 1'b0;
            end
            @(negedge clk);
            check($sformatf("stall_idx%0d", c),  dump_idx,  7);
            check($sformatf("stall_data%0d", c), dump_data, 32'h77);
        end
        dump_ready = 1'b1;
        @(negedge clk);
        check("stall_next_idx",  dump_idx,  8);
        check("stall_next_data", dump_data, 32'h88);
        wait_done();
        tick();
        start_dump();
        wait_beat(7);
        check("redump_data7", dump_data, 32'h1234);
        wait_done();

        // Reset in the middle of a dump.
        tick();
        start_dump();
        wait_beat(12);
        #1 reset = 1'b1;
        #1;
        check("midrst_valid", dump_valid, 1'b0);
        check("midrst_busy",  dump_busy,  1'b0);
        check("midrst_done",  dump_done,  1'b0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("midrst_nodone%0d", c), dump_done, 1'b0);
        end
        tick();
        start_dump();
        @(negedge clk);
        check("restart_valid", dump_valid, 1'b1);
        check("restart_idx",   dump_idx,   0);
        wait_done();

        // Randomized traffic against the model.
        tick();
        for (int n = 0; n < 3000; n++) begin
            we         = ($urandom_range(0, 1) == 1);
            waddr      = AW'($urandom_range(0, NREGS - 1));
            wdata      = $urandom;
            for (int k = 0; k < NRD; k++) begin
                raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr
                                                                : AW'($urandom_range(0, NREGS - 1));
            end
            dump_start = ($urandom_range(0, 19) == 0);
            dump_ready = ($urandom_range(0, 9) < 7);
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; we = 1'b0; dump_start = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of registers, 2..256; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  AW  write index.
- wdata  input  XLEN  write data.
- raddr  input  NRD*AW  read indices; port k is slice k.
- rdata  output  NRD*XLEN  read data; port k is slice k.
- dump_start  input  1  request a full register dump.
- dump_busy  output  1  dump in progress.
- dump_valid  output  1  dump beat valid.
- dump_ready  input  1  consumer accepts beat.
- dump_idx  output  AW  index of the current beat.
- dump_data  output  XLEN  register value of the current beat.
- dump_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-005 SHALL write wdata to RF[waddr] on the rising edge when we=1, waddr!=0 and waddr<NREGS; all other writes are dropped.
REQ-006 SHALL hold RF[0] at 0 permanently.
REQ-007 SHALL drive each rdata slice combinationally from RF[raddr_k]; raddr_k>=NREGS SHALL read 0.
REQ-008 SHALL implement dump FSM states IDLE, SEND, DONE.
- IDLE: dump_start=1 at an edge -> SEND, idx=0, beat register loaded.
- SEND: on valid&ready, last index NREGS-1 -> DONE, else idx+1 and reload.
- DONE: dump_done=1 for exactly one cycle -> IDLE.
REQ-009 SHALL assert dump_valid from the first cycle after dump_start (latency 1) until the last beat is accepted; beats SHALL be in ascending index order with no gaps.
REQ-010 SHALL register dump_data: load RF[idx] at the edge entering SEND or advancing idx, taking the pre-edge value when a same-edge write hits that index.
REQ-011 SHALL hold dump_idx and dump_data stable while dump_valid=1 and dump_ready=0, even if RF[dump_idx] is written.
REQ-012 SHALL assert dump_busy in SEND and DONE; dump_start SHALL be ignored while busy.
REQ-013 SHALL let normal reads and writes proceed unaffected during a dump.
REQ-014 SHALL treat dump_ready with dump_valid=0 as a no-op.

Reset
REQ-015 SHALL, on reset=1, immediately clear all RF entries, dump_idx and dump_data to 0, force FSM to IDLE, and hold dump_valid, dump_busy and dump_done at 0, including mid-dump.
REQ-016 SHALL leave rdata at 0 during reset, since all entries are 0.

Configuration
REQ-017 SHALL provide macro REGFILE_BYPASS_EN.
- Defined: a read port whose raddr equals waddr, with we=1 and waddr!=0, returns wdata combinationally in the same cycle.
- Undefined: that port returns the old RF contents until after the edge.

Verification
REQ-018 Reset clear: write RF[5]=0xDEADBEEF, pulse reset -> rdata(raddr=5)=0, dump_valid=0.
REQ-019 x0 hard-wired zero: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata(raddr=0)=0.
REQ-020 Full dump: RF[i]=i*0x11 for i=1..31, dump_start with dump_ready=1 constant -> 32 beats idx 0..31, data 0x0,0x11..0x20F, dump_done pulse in the cycle after the last beat, busy low the cycle after that.
REQ-021 Backpressure: dump_ready=0 for 3 cycles at idx=7, with RF[7] written to 0x1234 during the stall -> idx=7 and data=0x77 held through the stall, then accepted; a later dump shows 0x1234.
REQ-022 Bypass: we=1, waddr=3, wdata=0xA5A5A5A5, raddr0=3 in the same cycle -> rdata0=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without it.
REQ-023 Reset mid-dump: reset asserted at idx=12 -> dump_valid=0, dump_busy=0, no dump_done pulse; a new dump_start restarts at idx=0.
